// File: rtl/addsub_arbiter_pkg.sv
// rtl/addsub_arbiter_pkg.sv - shared FSM state type and requester index constants
package addsub_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/addsub_arbiter_addsubovf.sv
// rtl/addsub_arbiter_addsubovf.sv - AddSubOvf: n-bit two's complement add/sub with signed overflow
module AddSubOvf #(
  parameter int n = 8
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic         i_sub,
  output logic [n-1:0] o_s,
  output logic         o_ovf
);

  logic [n-1:0] w_b_eff;

  // Subtraction as a + ~b + 1 so the overflow rule is the same for both ops,
  // including b = most-negative.
  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign o_s     = i_a + w_b_eff + {{(n-1){1'b0}}, i_sub};
  assign o_ovf   = (i_a[n-1] == w_b_eff[n-1]) && (o_s[n-1] != i_a[n-1]);

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin add/sub unit; ADDSUB_FLAGS_EN adds z/n flags
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic         sub0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic         sub1,
  output logic         gnt1,
  output logic         out_valid,
  output logic         out_id,
  output logic [N-1:0] s,
  output logic         ovf,
  output logic         busy
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic         z,
  output logic         n
`endif
);

  state_t       r_state, w_next;
  logic         r_ptr;
  logic [N-1:0] r_a, r_b;
  logic         r_sub, r_id;
  logic [N-1:0] r_s;
  logic         r_ovf, r_out_id;
  logic [N-1:0] w_s;
  logic         w_ovf;

  AddSubOvf #(.n(N)) u_addsub (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_sub (r_sub),
    .o_s   (w_s),
    .o_ovf (w_ovf)
  );

  always_comb begin
    w_next    = r_state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        // Requester 0 wins unless requester 1 also asks and 0 was granted last.
        gnt0 = req0 && (!req1 || (r_ptr == REQ1));
        gnt1 = req1 && !gnt0;
        if (req0 || req1) w_next = CALC;
      end
      CALC: w_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= REQ1;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_id     <= REQ0;
      r_s      <= '0;
      r_ovf    <= 1'b0;
      r_out_id <= REQ0;
    end else begin
      r_state <= w_next;
      if (gnt0 || gnt1) begin
        r_a   <= gnt1 ? a1 : a0;
        r_b   <= gnt1 ? b1 : b0;
        r_sub <= gnt1 ? sub1 : sub0;
        r_id  <= gnt1 ? REQ1 : REQ0;
        r_ptr <= gnt1 ? REQ1 : REQ0;
      end
      if (r_state == CALC) begin
        r_s      <= w_s;
        r_ovf    <= w_ovf;
        r_out_id <= r_id;
      end
    end
  end

  assign s      = r_s;
  assign ovf    = r_ovf;
  assign out_id = r_out_id;
  assign busy   = (r_state != IDLE);

`ifdef ADDSUB_FLAGS_EN
  logic r_z, r_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else if (r_state == CALC) begin
      r_z <= (w_s == '0);
      r_n <= w_s[N-1];
    end
  end

  assign z = r_z;
  assign n = r_n;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed vector bench for addsub_arbiter (z/n checked when ADDSUB_FLAGS_EN)
module tb_addsub_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, sub0, req1, sub1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, out_valid, out_id, ovf, busy;
  logic [N-1:0] s;
`ifdef ADDSUB_FLAGS_EN
  logic         z, n;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .sub0      (sub0),
    .gnt0      (gnt0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .sub1      (sub1),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_id    (out_id),
    .s         (s),
    .ovf       (ovf),
    .busy      (busy)
`ifdef ADDSUB_FLAGS_EN
    ,
    .z         (z),
    .n         (n)
`endif
  );

  typedef struct {
    logic       r0;
    logic [7:0] va0, vb0;
    logic       vs0;
    logic       r1;
    logic [7:0] va1, vb1;
    logic       vs1;
    logic       eg0, eg1;
    logic [7:0] es;
    logic       eovf;
    logic       eid;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] prev_s;

    //            r0  a0     b0     s0    r1  a1     b1     s1    g0  g1  s      ovf id
    vecs[0]  = '{1'b1, 8'h70, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h90, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, 8'h01, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 8'h03, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 8'h00, 8'h80, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h33, 8'h44, 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h10, 8'h10, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h7F, 8'h80, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

    reset = 1'b1;
    req0 = 1'b0; a0 = '0; b0 = '0; sub0 = 1'b0;
    req1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_s", s, 8'h00);
    check("rst_ovf", ovf, 1'b0);
    check("rst_out_id", out_id, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", {gnt0, gnt1}, 2'b00);
`ifdef ADDSUB_FLAGS_EN
    check("rst_zn", {z, n}, 2'b00);
`endif
    reset = 1'b0;

    prev_s = 8'h00;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      req0 = vecs[i].r0; a0 = vecs[i].va0; b0 = vecs[i].vb0; sub0 = vecs[i].vs0;
      req1 = vecs[i].r1; a1 = vecs[i].va1; b1 = vecs[i].vb1; sub1 = vecs[i].vs1;
      #1;
      check($sformatf("v%0d_gnt0", i), gnt0, vecs[i].eg0);
      check($sformatf("v%0d_gnt1", i), gnt1, vecs[i].eg1);
      check($sformatf("v%0d_idle_busy", i), busy, 1'b0);
      @(negedge clk);
      // Disturb inputs after the grant; the in-flight op must not notice.
      req0 = 1'b0; req1 = 1'b0;
      a0 = ~a0; b0 = ~b0; sub0 = ~sub0;
      a1 = ~a1; b1 = ~b1; sub1 = ~sub1;
      #1;
      check($sformatf("v%0d_calc_busy", i), busy, 1'b1);
      check($sformatf("v%0d_calc_gnt", i), {gnt0, gnt1}, 2'b00);
      check($sformatf("v%0d_calc_valid", i), out_valid, 1'b0);
      check($sformatf("v%0d_calc_hold_s", i), s, prev_s);
      @(negedge clk);
      check($sformatf("v%0d_out_valid", i), out_valid, 1'b1);
      check($sformatf("v%0d_s", i), s, vecs[i].es);
      check($sformatf("v%0d_ovf", i), ovf, vecs[i].eovf);
      check($sformatf("v%0d_out_id", i), out_id, vecs[i].eid);
      check($sformatf("v%0d_out_gnt", i), {gnt0, gnt1}, 2'b00);
`ifdef ADDSUB_FLAGS_EN
      check($sformatf("v%0d_z", i), z, (vecs[i].es == 8'h00));
      check($sformatf("v%0d_n", i), n, vecs[i].es[7]);
`endif
      prev_s = vecs[i].es;
    end

    // Round-robin under continuous contention, starting from reset.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h01; sub0 = 1'b0;
    req1 = 1'b1; a1 = 8'h10; b1 = 8'h01; sub1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("rr%0d_gnt0", k), gnt0, (k == 0 || k == 6));
      check($sformatf("rr%0d_gnt1", k), gnt1, (k == 3 || k == 9));
      if (k % 3 == 2) begin
        check($sformatf("rr%0d_valid", k), out_valid, 1'b1);
        check($sformatf("rr%0d_out_id", k), out_id, (k == 5 || k == 11));
        check($sformatf("rr%0d_s", k), s, (k == 5 || k == 11) ? 8'h0F : 8'h02);
      end else begin
        check($sformatf("rr%0d_valid", k), out_valid, 1'b0);
      end
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset during CALC aborts the operation.
    @(negedge clk);
    req0 = 1'b1; a0 = 8'h12; b0 = 8'h34; sub0 = 1'b0;
    #1;
    check("abort_gnt0", gnt0, 1'b1);
    @(negedge clk);
    req0 = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_s", s, 8'h00);
    check("abort_ovf", ovf, 1'b0);
    check("abort_out_id", out_id, 1'b0);
    check("abort_gnt", {gnt0, gnt1}, 2'b00);
    @(negedge clk);
    check("abort_valid2", out_valid, 1'b0);
    reset = 1'b0;
    req1 = 1'b1; a1 = 8'h09; b1 = 8'h04; sub1 = 1'b1;
    #1;
    check("post_rst_gnt1", gnt1, 1'b1);
    check("post_rst_gnt0", gnt0, 1'b0);
    @(negedge clk);
    req1 = 1'b0;
    check("post_rst_calc_valid", out_valid, 1'b0);
    @(negedge clk);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_s", s, 8'h05);
    check("post_rst_ovf", ovf, 1'b0);
    check("post_rst_out_id", out_id, 1'b1);
    @(negedge clk);
    check("post_rst_idle_valid", out_valid, 1'b0);
    check("post_rst_hold_s", s, 8'h05);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request, held high until gnt0.
REQ-005 a0, b0  input  N each  requester 0 operands, two's complement.
REQ-006 sub0  input  1  requester 0 op select: 1 = a0-b0, 0 = a0+b0.
REQ-007 gnt0  output  1  one-cycle pulse: requester 0 operands captured this edge.
REQ-008 req1, a1, b1, sub1, gnt1: same as REQ-004..REQ-007 for requester 1.
REQ-009 out_valid  output  1  one-cycle pulse: s/ovf/out_id hold a new result.
REQ-010 out_id  output  1  requester index of the current result.
REQ-011 s  output  N  registered sum/difference, modulo 2^N.
REQ-012 ovf  output  1  registered signed-overflow flag for s.
REQ-013 busy  output  1  high in CALC and OUT states.

Function
REQ-014 FSM states SHALL be IDLE, CALC, OUT; one operation occupies exactly 3 cycles.
REQ-015 IDLE: if req0 or req1 is high, gnt of the selected requester is high (combinational from FSM state, req and the pointer), its a/b/sub/index latch at the clock edge, and next state is CALC; otherwise the FSM stays in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; with one requesting, grant it regardless of pointer.
REQ-017 The last-granted pointer SHALL update only on a grant.
REQ-018 CALC: latched operands drive one shared add/sub-with-overflow datapath; s, ovf and out_id register at the edge and the next state is OUT.
REQ-019 OUT: out_valid SHALL be high for exactly this cycle; next state is IDLE.
REQ-020 Latency: grant in cycle T gives out_valid in cycle T+2; the next grant is possible in T+3.
REQ-021 gnt0 and gnt1 SHALL never be high together and SHALL be low outside IDLE.
REQ-022 A request dropped before it is granted SHALL be discarded with no side effects.
REQ-023 req/a/b/sub changes after the grant SHALL NOT affect the in-flight operation.
REQ-024 ovf SHALL be 1 exactly when the true signed result is outside [-2^(N-1), 2^(N-1)-1], including a-b with b = most-negative.
REQ-025 s, ovf and out_id SHALL hold their values between results.

Reset
REQ-026 reset SHALL force IDLE, pointer = 1 (requester 0 wins the first contention), and s = 0, ovf = 0, out_id = 0, out_valid = 0, gnt0 = gnt1 = 0, busy = 0.
REQ-027 Reset asserted during CALC or OUT SHALL abort the operation; no out_valid is produced for it.

Configuration
REQ-028 Macro ADDSUB_FLAGS_EN defined: add registered outputs z (s == 0) and n (s[N-1]), 1 bit each, updated with s, reset to 0.
REQ-029 Macro ADDSUB_FLAGS_EN undefined: ports z and n and their registers SHALL be absent; all other behaviour is identical.

Structure
REQ-030 The shared package SHALL hold the FSM state enum (IDLE, CALC, OUT) and the requester-index constants REQ0 = 0 and REQ1 = 1.
REQ-031 The datapath SHALL be one instance of the existing AddSubOvf module with parameter n = N; no other arithmetic in this block.

Verification (N = 8)
REQ-032 Lone req0 with a0 = 0x70, b0 = 0x20, sub0 = 0 -> gnt0 at T; at T+2, out_valid = 1, s = 0x90, ovf = 1, out_id = 0.
REQ-033 Lone req1 with a1 = 0x80, b1 = 0x01, sub1 = 1 -> s = 0x7F, ovf = 1, out_id = 1; then a1 = 0x05, b1 = 0x03, sub1 = 1 -> s = 0x02, ovf = 0.
REQ-034 After reset, req0 and req1 held high together -> grant order 0, 1, 0, 1, with grants 3 cycles apart and out_id matching.
REQ-035 Grant req0, then assert reset in CALC -> no out_valid, all outputs 0, and IDLE on release; a new req1 is granted next cycle.
REQ-036 With ADDSUB_FLAGS_EN: a0 = 0x05, b0 = 0x05, sub0 = 1 -> s = 0x00, z = 1, n = 0, ovf = 0; a0 = 0x00, b0 = 0x01, sub0 = 1 -> s = 0xFF, n = 1, z = 0.
